// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// State encoding is visible on state_o, so values are fixed.
package pipe_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline register control: write enables, bubbles and flushes
// from hazard, branch and data-memory handshake inputs.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hazard_stall_i,
  input  logic               hazard_pcwrite_i,
  input  logic               branch_flush_i,
  input  logic               dmem_req_i,
  input  logic               dmem_ready_i,
  output logic               pc_we_o,
  output logic               ifid_we_o,
  output logic               ifid_flush_o,
  output logic               idex_we_o,
  output logic               idex_bubble_o,
  output logic               exmem_we_o,
  output logic               memwb_we_o,
  output logic               memwb_bubble_o,
  output logic [STATE_W-1:0] state_o,
  output logic               error_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_n;
  logic [WW-1:0] wait_q, wait_n;
  logic          freeze;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_n;
      wait_q  <= wait_n;
    end
  end

  always_comb begin
    state_n        = state_q;
    wait_n         = wait_q;
    freeze         = 1'b0;
    pc_we_o        = 1'b1;
    ifid_we_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_we_o      = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_we_o     = 1'b1;
    memwb_we_o     = 1'b1;
    memwb_bubble_o = 1'b0;

    if (!rst_i) begin
      unique case (state_q)
        ST_RUN: begin
          if (dmem_req_i && !dmem_ready_i) begin
            freeze  = 1'b1;
            state_n = ST_MEM_WAIT;
            wait_n  = WW'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready_i) begin
            freeze = 1'b1;
            if (wait_q >= WAIT_LIM) begin
              state_n = ST_ERROR;
            end else begin
              wait_n = wait_q + WW'(1);
            end
          end else begin
            state_n = ST_RUN;
            wait_n  = '0;
          end
        end
        ST_ERROR: begin
          freeze = 1'b1;
        end
        default: begin
          freeze  = 1'b1;
          state_n = ST_ERROR;
        end
      endcase

      // PCWrite must be the inverse of Stall; anything else is fatal
      if ((state_q != ST_ERROR) &&
          (hazard_pcwrite_i == hazard_stall_i)) begin
        state_n = ST_ERROR;
      end

      if (freeze) begin
        pc_we_o        = 1'b0;
        ifid_we_o      = 1'b0;
        idex_we_o      = 1'b0;
        exmem_we_o     = 1'b0;
        memwb_we_o     = 1'b0;
        memwb_bubble_o = 1'b1;
      end else if (hazard_stall_i) begin
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (branch_flush_i) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

  assign state_o = state_q;
  assign error_o = (state_q == ST_ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .clear (rst_i),
    .en    (!pc_we_o),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .clear (rst_i),
    .en    (ifid_flush_o),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table,
// saturation sequence, then random stimulus against a model.
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 4;
  localparam int TO    = 4;
  localparam int SAT   = 15;

  localparam logic [7:0] O_IDLE  = 8'b1101_0110;
  localparam logic [7:0] O_FRZ   = 8'b0000_0001;
  localparam logic [7:0] O_STALL = 8'b0001_1110;
  localparam logic [7:0] O_FLUSH = 8'b1111_0110;

  logic clk = 1'b0;
  logic rst, hz_stall, hz_pcw, br_flush, dreq, drdy;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
  logic exmem_we, memwb_we, memwb_bubble, err;
  logic [1:0] st;
  logic [CNT_W-1:0] scnt, fcnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .hazard_stall_i   (hz_stall),
    .hazard_pcwrite_i (hz_pcw),
    .branch_flush_i   (br_flush),
    .dmem_req_i       (dreq),
    .dmem_ready_i     (drdy),
    .pc_we_o          (pc_we),
    .ifid_we_o        (ifid_we),
    .ifid_flush_o     (ifid_flush),
    .idex_we_o        (idex_we),
    .idex_bubble_o    (idex_bubble),
    .exmem_we_o       (exmem_we),
    .memwb_we_o       (memwb_we),
    .memwb_bubble_o   (memwb_bubble),
    .state_o          (st),
    .error_o          (err),
    .stall_cnt_o      (scnt),
    .flush_cnt_o      (fcnt)
  );

  typedef struct {
    logic [5:0] in;
    logic [7:0] o;
    int         st;
    int         er;
    int         sc;
    int         fc;
    bit         chk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [5:0] in, input logic [7:0] o,
                              input int s, input int e, input int sc,
                              input int fc, input bit chk);
    vec_t v;
    v.in = in; v.o = o; v.st = s; v.er = e;
    v.sc = sc; v.fc = fc; v.chk = chk;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
            exmem_we, memwb_we, memwb_bubble};
  endfunction

  task automatic drive(input logic [5:0] in);
    @(posedge clk);
    #1;
    {rst, hz_stall, hz_pcw, br_flush, dreq, drdy} = in;
    #3;
  endtask

  task automatic check(input string nm, input int idx, input logic [7:0] o,
                       input int s, input int e, input int sc, input int fc,
                       input bit chk);
    logic [7:0] ao;
    bit bad;
    ao = outs();
    bad = (ao !== o);
    if (chk) begin
      bad = bad || (int'(st) != s) || (int'(err) != e) ||
            (int'(scnt) != sc) || (int'(fcnt) != fc);
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s #%0d: got out=%b st=%0d err=%b sc=%0d fc=%0d, want out=%b st=%0d err=%0d sc=%0d fc=%0d",
               nm, idx, ao, st, err, scnt, fcnt, o, s, e, sc, fc);
    end
  endtask

  // Reference model: per-cycle state in spec terms
  int ms, mw, msc, mfc;

  function automatic logic [7:0] model_out(input logic [5:0] in);
    logic r, s, f, q, y;
    r = in[5]; s = in[4]; f = in[2]; q = in[1]; y = in[0];
    if (r) return O_IDLE;
    if (ms == 2) return O_FRZ;
    if (ms == 0 && q && !y) return O_FRZ;
    if (ms == 1 && !y) return O_FRZ;
    if (s) return O_STALL;
    if (f) return O_FLUSH;
    return O_IDLE;
  endfunction

  task automatic model_step(input logic [5:0] in, input logic [7:0] o);
    int nxt;
    if (in[5]) begin
      ms = 0; mw = 0; msc = 0; mfc = 0;
      return;
    end
    if (!o[7] && msc < SAT) msc++;
    if (o[5] && mfc < SAT) mfc++;
    nxt = ms;
    if (ms == 0 && in[1] && !in[0]) begin
      nxt = 1; mw = 1;
    end else if (ms == 1) begin
      if (!in[0]) begin
        mw++;
        if (mw >= TO) nxt = 2;
      end else begin
        nxt = 0;
      end
    end
    if (ms != 2 && in[3] == in[4]) nxt = 2;
    ms = nxt;
  endtask

  // in = {rst, stall, pcwrite, flush, req, ready}
  localparam logic [5:0] I_RST  = 6'b101000;
  localparam logic [5:0] I_IDLE = 6'b001000;
  localparam logic [5:0] I_STF  = 6'b010100;
  localparam logic [5:0] I_FL   = 6'b001100;
  localparam logic [5:0] I_REQ  = 6'b001010;
  localparam logic [5:0] I_RDY  = 6'b001011;
  localparam logic [5:0] I_RSTF = 6'b010111;
  localparam logic [5:0] I_P11  = 6'b011000;
  localparam logic [5:0] I_P00  = 6'b000000;

  initial begin
    logic [5:0] in;
    logic [7:0] eo;
    {rst, hz_stall, hz_pcw, br_flush, dreq, drdy} = I_RST;

    tbl.push_back(mk(I_RST,  O_IDLE,  0, 0, 0, 0, 0));
    tbl.push_back(mk(I_RST,  O_IDLE,  0, 0, 0, 0, 1));
    tbl.push_back(mk(I_RST,  O_IDLE,  0, 0, 0, 0, 1));
    tbl.push_back(mk(I_IDLE, O_IDLE,  0, 0, 0, 0, 1));
    tbl.push_back(mk(I_STF,  O_STALL, 0, 0, 0, 0, 1));
    tbl.push_back(mk(I_IDLE, O_IDLE,  0, 0, 1, 0, 1));
    tbl.push_back(mk(I_FL,   O_FLUSH, 0, 0, 1, 0, 1));
    tbl.push_back(mk(I_IDLE, O_IDLE,  0, 0, 1, 1, 1));
    tbl.push_back(mk(I_REQ,  O_FRZ,   0, 0, 1, 1, 1));
    tbl.push_back(mk(I_REQ,  O_FRZ,   1, 0, 2, 1, 1));
    tbl.push_back(mk(I_REQ,  O_FRZ,   1, 0, 3, 1, 1));
    tbl.push_back(mk(I_RDY,  O_IDLE,  1, 0, 4, 1, 1));
    tbl.push_back(mk(I_IDLE, O_IDLE,  0, 0, 4, 1, 1));
    tbl.push_back(mk(I_REQ,  O_FRZ,   0, 0, 4, 1, 1));
    tbl.push_back(mk(I_RSTF, O_STALL, 1, 0, 5, 1, 1));
    tbl.push_back(mk(I_IDLE, O_IDLE,  0, 0, 6, 1, 1));
    tbl.push_back(mk(I_REQ,  O_FRZ,   0, 0, 6, 1, 1));
    tbl.push_back(mk(I_REQ,  O_FRZ,   1, 0, 7, 1, 1));
    tbl.push_back(mk(I_REQ,  O_FRZ,   1, 0, 8, 1, 1));
    tbl.push_back(mk(I_REQ,  O_FRZ,   1, 0, 9, 1, 1));
    tbl.push_back(mk(I_IDLE, O_FRZ,   2, 1, 10, 1, 1));
    tbl.push_back(mk(I_RDY,  O_FRZ,   2, 1, 11, 1, 1));
    tbl.push_back(mk(I_RST,  O_IDLE,  2, 1, 12, 1, 1));
    tbl.push_back(mk(I_IDLE, O_IDLE,  0, 0, 0, 0, 1));
    tbl.push_back(mk(I_P11,  O_STALL, 0, 0, 0, 0, 1));
    tbl.push_back(mk(I_IDLE, O_FRZ,   2, 1, 1, 0, 1));
    tbl.push_back(mk(I_IDLE, O_FRZ,   2, 1, 2, 0, 1));
    tbl.push_back(mk(I_RST,  O_IDLE,  2, 1, 3, 0, 1));
    tbl.push_back(mk(I_IDLE, O_IDLE,  0, 0, 0, 0, 1));
    tbl.push_back(mk(I_P00,  O_IDLE,  0, 0, 0, 0, 1));
    tbl.push_back(mk(I_IDLE, O_FRZ,   2, 1, 0, 0, 1));
    tbl.push_back(mk(I_RST,  O_IDLE,  2, 1, 1, 0, 1));
    tbl.push_back(mk(I_IDLE, O_IDLE,  0, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      check("vec", i, tbl[i].o, tbl[i].st, tbl[i].er,
            tbl[i].sc, tbl[i].fc, tbl[i].chk);
    end

    for (int i = 0; i < 20; i++) begin
      drive(I_FL);
      if (i == 15 || i == 19) check("flush_sat", i, O_FLUSH, 0, 0, 0, 15, 1);
    end
    drive(I_IDLE);
    check("flush_sat_end", 20, O_IDLE, 0, 0, 0, 15, 1);

    drive(I_RST);
    model_step(I_RST, O_IDLE);
    for (int i = 0; i < 3000; i++) begin
      in[5] = ($urandom_range(0, 79) == 0);
      in[4] = ($urandom_range(0, 3) == 0);
      in[3] = ($urandom_range(0, 63) == 0) ? in[4] : ~in[4];
      in[2] = ($urandom_range(0, 2) == 0);
      in[1] = ($urandom_range(0, 3) == 0);
      in[0] = ($urandom_range(0, 2) != 0) || (ms == 1 && $urandom_range(0, 1) == 0);
      drive(in);
      eo = model_out(in);
      check("rand", i, eo, ms, (ms == 2) ? 1 : 0, msc, mfc, 1);
      model_step(in, eo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
